// File: rtl/stack_sequencer.sv
// Fetch/decode/execute FSM for the stack processor. Defining STACK_SEQ_ADD_EN makes opcode 0x21 (add) legal.
// Latency: 3-9 cycles from step to done. Backpressure: step is only sampled in IDLE.
module stack_sequencer #(
  parameter int SP_W   = 8,
  parameter int DATA_W = 32,
  parameter int PC_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  output logic [PC_W-1:0]   rom_addr,
  input  logic [7:0]        rom_data,
  output logic [SP_W-1:0]   ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] tos,
  output logic              tos_valid,
  output logic [PC_W-1:0]   pc,
  output logic              busy,
  output logic              done,
  output logic              halted,
  output logic              fault,
  output logic [1:0]        fault_code
);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_FETCH     = 4'd1;
  localparam logic [3:0] S_DECODE    = 4'd2;
  localparam logic [3:0] S_IMM       = 4'd3;
  localparam logic [3:0] S_READ      = 4'd4;
  localparam logic [3:0] S_READ_WAIT = 4'd5;
  localparam logic [3:0] S_WRITE     = 4'd6;
  localparam logic [3:0] S_HALT      = 4'd7;
  localparam logic [3:0] S_FAULT     = 4'd8;

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_POP   = 8'h02;
  localparam logic [7:0] OP_PUSH  = 8'h10;
  localparam logic [7:0] OP_PUSH0 = 8'h11;
  localparam logic [7:0] OP_INC   = 8'h20;
  localparam logic [7:0] OP_ADD   = 8'h21;
  localparam logic [7:0] OP_HALT  = 8'hFF;

  localparam logic [1:0] FC_OVERFLOW  = 2'b01;
  localparam logic [1:0] FC_UNDERFLOW = 2'b10;
  localparam logic [1:0] FC_ILLEGAL   = 2'b11;

  localparam logic [SP_W-1:0] SP_EMPTY = '1;
  localparam logic [SP_W-1:0] SP_FULL  = '0;

  logic [3:0]      state;
  logic [7:0]      op;
  logic [2:0]      cnt;
  logic [SP_W-1:0] sp;
  logic [SP_W-1:0] sp_p1;
  logic [SP_W-1:0] sp_p2;
  logic            is_empty;
  logic            is_full;
  logic            has_two;

  assign sp_p1    = sp + SP_W'(1);
  assign sp_p2    = sp + SP_W'(2);
  assign is_empty = (sp == SP_EMPTY);
  assign is_full  = (sp == SP_FULL);
  assign has_two  = !is_empty && (sp_p1 != SP_EMPTY);

  assign busy   = (state != S_IDLE) && (state != S_HALT) && (state != S_FAULT);
  assign halted = (state == S_HALT);
  assign fault  = (state == S_FAULT);
  // Gated by rst so a reset landing on a WRITE cycle never commits to RAM.
  assign ram_we = (state == S_WRITE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      op         <= 8'h00;
      cnt        <= 3'd0;
      sp         <= SP_EMPTY;
      tos        <= '0;
      tos_valid  <= 1'b0;
      pc         <= '0;
      rom_addr   <= '0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      done       <= 1'b0;
      fault_code <= 2'b00;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (step) begin
            rom_addr <= pc;
            state    <= S_FETCH;
          end
        end

        S_FETCH: state <= S_DECODE;

        S_DECODE: begin
          op <= rom_data;
          case (rom_data)
            OP_NOP: begin
              pc    <= pc + PC_W'(1);
              done  <= 1'b1;
              state <= S_IDLE;
            end
            OP_HALT: state <= S_HALT;
            OP_PUSH: begin
              if (is_full) begin
                fault_code <= FC_OVERFLOW;
                state      <= S_FAULT;
              end else begin
                rom_addr <= pc + PC_W'(1);
                cnt      <= 3'd0;
                state    <= S_IMM;
              end
            end
            OP_PUSH0: begin
              if (is_full) begin
                fault_code <= FC_OVERFLOW;
                state      <= S_FAULT;
              end else begin
                ram_addr  <= sp;
                ram_wdata <= '0;
                state     <= S_WRITE;
              end
            end
            OP_POP: begin
              if (is_empty) begin
                fault_code <= FC_UNDERFLOW;
                state      <= S_FAULT;
              end else begin
                sp <= sp_p1;
                // Popping the last entry leaves nothing to cache, so skip the RAM read.
                if (sp_p1 == SP_EMPTY) begin
                  tos_valid <= 1'b0;
                  pc        <= pc + PC_W'(1);
                  done      <= 1'b1;
                  state     <= S_IDLE;
                end else begin
                  ram_addr <= sp_p2;
                  state    <= S_READ;
                end
              end
            end
            OP_INC: begin
              if (is_empty) begin
                fault_code <= FC_UNDERFLOW;
                state      <= S_FAULT;
              end else begin
                ram_addr  <= sp_p1;
                ram_wdata <= tos + DATA_W'(1);
                state     <= S_WRITE;
              end
            end
`ifdef STACK_SEQ_ADD_EN
            OP_ADD: begin
              if (!has_two) begin
                fault_code <= FC_UNDERFLOW;
                state      <= S_FAULT;
              end else begin
                ram_addr <= sp_p2;
                state    <= S_READ;
              end
            end
`endif
            default: begin
              fault_code <= FC_ILLEGAL;
              state      <= S_FAULT;
            end
          endcase
        end

        // Byte k arrives one cycle after its address, so five cycles cover four bytes.
        S_IMM: begin
          if (cnt != 3'd0) begin
            ram_wdata <= {ram_wdata[DATA_W-9:0], rom_data};
          end
          if (cnt < 3'd3) begin
            rom_addr <= rom_addr + PC_W'(1);
          end
          if (cnt == 3'd4) begin
            ram_addr <= sp;
            state    <= S_WRITE;
          end
          cnt <= cnt + 3'd1;
        end

        S_READ: state <= S_READ_WAIT;

        S_READ_WAIT: begin
          if (op == OP_POP) begin
            tos   <= ram_rdata;
            pc    <= pc + PC_W'(1);
            done  <= 1'b1;
            state <= S_IDLE;
          end else begin
            ram_wdata <= ram_rdata + tos;
            state     <= S_WRITE;
          end
        end

        S_WRITE: begin
          tos       <= ram_wdata;
          tos_valid <= 1'b1;
          if (op == OP_ADD) begin
            sp <= sp_p1;
          end else if (op != OP_INC) begin
            sp <= sp - SP_W'(1);
          end
          pc    <= pc + ((op == OP_PUSH) ? PC_W'(5) : PC_W'(1));
          done  <= 1'b1;
          state <= S_IDLE;
        end

        S_HALT:  state <= S_HALT;
        S_FAULT: state <= S_FAULT;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_sequencer.sv
// Bench for stack_sequencer: table of single-instruction steps checked through a scoreboard, plus reset corner cases.
module tb_stack_sequencer;
  localparam int SP_W   = 8;
  localparam int DATA_W = 32;
  localparam int PC_W   = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              step;
  logic [PC_W-1:0]   rom_addr;
  logic [7:0]        rom_data;
  logic [SP_W-1:0]   ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] tos;
  logic              tos_valid;
  logic [PC_W-1:0]   pc;
  logic              busy;
  logic              done;
  logic              halted;
  logic              fault;
  logic [1:0]        fault_code;

  always #5 clk = ~clk;

  stack_sequencer #(.SP_W(SP_W), .DATA_W(DATA_W), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .step(step),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata),
    .tos(tos), .tos_valid(tos_valid), .pc(pc), .busy(busy), .done(done),
    .halted(halted), .fault(fault), .fault_code(fault_code)
  );

  logic [7:0]  rom [0:65535];
  logic [31:0] mem [0:255];

  always @(posedge clk) begin
    rom_data  <= rom[rom_addr];
    ram_rdata <= mem[ram_addr];
    if (ram_we) mem[ram_addr] <= ram_wdata;
  end

  typedef struct {
    bit          r_first;
    logic [7:0]  op;
    logic [31:0] imm;
    logic [31:0] e_tos;
    logic        e_vld;
    logic [7:0]  e_sp;
    logic [15:0] e_pc;
    logic [1:0]  e_st;   // 0 idle, 1 halted, 2 fault
    logic [1:0]  e_code;
    int          e_lat;
    logic        e_we;
    bit          r_chk;
    logic [7:0]  r_addr;
    logic [31:0] r_val;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int total  = 0;
  int passed = 0;
  int vidx   = 0;
  logic [15:0] ipc;

  function automatic vec_t mk(bit r, logic [7:0] op, logic [31:0] imm, logic [31:0] t, logic v,
                              logic [7:0] s, logic [15:0] p, logic [1:0] st, logic [1:0] code,
                              int lat, logic we, bit rc, logic [7:0] ra, logic [31:0] rv);
    vec_t x;
    x.r_first = r; x.op = op; x.imm = imm; x.e_tos = t; x.e_vld = v; x.e_sp = s; x.e_pc = p;
    x.e_st = st; x.e_code = code; x.e_lat = lat; x.e_we = we; x.r_chk = rc; x.r_addr = ra; x.r_val = rv;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s (vec %0d): got %h, expected %h", name, vidx, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    step = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step_only();
    @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    vec_t e;
    int   lat;
    logic we_seen;
    if (v.r_first) begin
      do_reset();
      ipc = 16'd0;
    end
    rom[ipc] = v.op;
    for (int b = 0; b < 4; b++) rom[ipc + 16'(b + 1)] = v.imm[31 - 8*b -: 8];
    exp_q.push_back(v);
    step_only();
    lat     = 0;
    we_seen = ram_we;
    while (!(done || halted || fault) && lat < 40) begin
      @(negedge clk);
      lat++;
      if (ram_we) we_seen = 1'b1;
    end
    e = exp_q.pop_front();
    check("latency", 32'(lat), 32'(e.e_lat));
    check("ram_we_seen", we_seen, e.e_we);
    check("tos", tos, e.e_tos);
    check("tos_valid", tos_valid, e.e_vld);
    check("sp", dut.sp, e.e_sp);
    check("pc", pc, e.e_pc);
    check("halted", halted, e.e_st == 2'd1);
    check("fault", fault, e.e_st == 2'd2);
    check("fault_code", fault_code, e.e_code);
    if (e.r_chk) check("ram_word", mem[e.r_addr], e.r_val);
    ipc = e.e_pc;
    vidx++;
  endtask

  initial begin
    rst  = 1'b1;
    step = 1'b0;
    for (int i = 0; i < 65536; i++) rom[i] = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_halted", halted, 0);
    check("rst_fault", fault, 0);
    check("rst_fault_code", fault_code, 0);
    check("rst_tos", tos, 0);
    check("rst_tos_valid", tos_valid, 0);
    check("rst_pc", pc, 0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_sp", dut.sp, 8'd255);

    // push 6, inc, inc, halt
    tbl.push_back(mk(1, 8'h10, 32'd6, 32'd6, 1, 8'd254, 16'd5, 0, 0, 8, 1, 1, 8'd255, 32'd6));
    tbl.push_back(mk(0, 8'h20, 32'd0, 32'd7, 1, 8'd254, 16'd6, 0, 0, 3, 1, 1, 8'd255, 32'd7));
    tbl.push_back(mk(0, 8'h20, 32'd0, 32'd8, 1, 8'd254, 16'd7, 0, 0, 3, 1, 1, 8'd255, 32'd8));
    tbl.push_back(mk(0, 8'hFF, 32'd0, 32'd8, 1, 8'd254, 16'd7, 1, 0, 2, 0, 0, 8'd0, 32'd0));
    // push 5, pop to empty, underflowing pop
    tbl.push_back(mk(1, 8'h10, 32'd5, 32'd5, 1, 8'd254, 16'd5, 0, 0, 8, 1, 1, 8'd255, 32'd5));
    tbl.push_back(mk(0, 8'h02, 32'd0, 32'd5, 0, 8'd255, 16'd6, 0, 0, 2, 0, 0, 8'd0, 32'd0));
    tbl.push_back(mk(0, 8'h02, 32'd0, 32'd5, 0, 8'd255, 16'd6, 2, 2, 2, 0, 0, 8'd0, 32'd0));
    // illegal opcode
    tbl.push_back(mk(1, 8'h37, 32'd0, 32'd0, 0, 8'd255, 16'd0, 2, 3, 2, 0, 0, 8'd0, 32'd0));
    // push all-ones, inc wraps to zero
    tbl.push_back(mk(1, 8'h10, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 8'd254, 16'd5, 0, 0, 8, 1, 1, 8'd255, 32'hFFFFFFFF));
    tbl.push_back(mk(0, 8'h20, 32'd0, 32'd0, 1, 8'd254, 16'd6, 0, 0, 3, 1, 1, 8'd255, 32'd0));
    // nop, push0, push, push, pop-with-read, inc, pop, pop
    tbl.push_back(mk(1, 8'h00, 32'd0, 32'd0, 0, 8'd255, 16'd1, 0, 0, 2, 0, 0, 8'd0, 32'd0));
    tbl.push_back(mk(0, 8'h11, 32'd0, 32'd0, 1, 8'd254, 16'd2, 0, 0, 3, 1, 1, 8'd255, 32'd0));
    tbl.push_back(mk(0, 8'h10, 32'd3, 32'd3, 1, 8'd253, 16'd7, 0, 0, 8, 1, 1, 8'd254, 32'd3));
    tbl.push_back(mk(0, 8'h10, 32'd4, 32'd4, 1, 8'd252, 16'd12, 0, 0, 8, 1, 1, 8'd253, 32'd4));
    tbl.push_back(mk(0, 8'h02, 32'd0, 32'd3, 1, 8'd253, 16'd13, 0, 0, 4, 0, 0, 8'd0, 32'd0));
    tbl.push_back(mk(0, 8'h20, 32'd0, 32'd4, 1, 8'd253, 16'd14, 0, 0, 3, 1, 1, 8'd254, 32'd4));
    tbl.push_back(mk(0, 8'h02, 32'd0, 32'd0, 1, 8'd254, 16'd15, 0, 0, 4, 0, 0, 8'd0, 32'd0));
    tbl.push_back(mk(0, 8'h02, 32'd0, 32'd0, 0, 8'd255, 16'd16, 0, 0, 2, 0, 0, 8'd0, 32'd0));
    // add: push 3, push 4, add; then add with a single entry
    tbl.push_back(mk(1, 8'h10, 32'd3, 32'd3, 1, 8'd254, 16'd5, 0, 0, 8, 1, 1, 8'd255, 32'd3));
    tbl.push_back(mk(0, 8'h10, 32'd4, 32'd4, 1, 8'd253, 16'd10, 0, 0, 8, 1, 1, 8'd254, 32'd4));
`ifdef STACK_SEQ_ADD_EN
    tbl.push_back(mk(0, 8'h21, 32'd0, 32'd7, 1, 8'd254, 16'd11, 0, 0, 5, 1, 1, 8'd255, 32'd7));
    tbl.push_back(mk(1, 8'h10, 32'd1, 32'd1, 1, 8'd254, 16'd5, 0, 0, 8, 1, 0, 8'd0, 32'd0));
    tbl.push_back(mk(0, 8'h21, 32'd0, 32'd1, 1, 8'd254, 16'd5, 2, 2, 2, 0, 0, 8'd0, 32'd0));
`else
    tbl.push_back(mk(0, 8'h21, 32'd0, 32'd4, 1, 8'd253, 16'd10, 2, 3, 2, 0, 0, 8'd0, 32'd0));
    tbl.push_back(mk(1, 8'h10, 32'd1, 32'd1, 1, 8'd254, 16'd5, 0, 0, 8, 1, 0, 8'd0, 32'd0));
    tbl.push_back(mk(0, 8'h21, 32'd0, 32'd1, 1, 8'd254, 16'd5, 2, 3, 2, 0, 0, 8'd0, 32'd0));
`endif
    foreach (tbl[i]) run_vec(tbl[i]);

    // Fill the stack with push0, then overflow on the next push.
    for (int i = 0; i < 255; i++)
      run_vec(mk(i == 0, 8'h11, 32'd0, 32'd0, 1, 8'(254 - i), 16'(i + 1), 0, 0, 3, 1, 1, 8'(255 - i), 32'd0));
    run_vec(mk(0, 8'h11, 32'd0, 32'd0, 1, 8'd0, 16'd255, 2, 1, 2, 0, 0, 8'd0, 32'd0));

    // Reset in the middle of a push immediate fetch.
    run_vec(mk(1, 8'h10, 32'd10, 32'd10, 1, 8'd254, 16'd5, 0, 0, 8, 1, 1, 8'd255, 32'd10));
    mem[254] = 32'hDEADBEEF;
    rom[5] = 8'h10; rom[6] = 8'h12; rom[7] = 8'h34; rom[8] = 8'h56; rom[9] = 8'h78;
    step_only();
    repeat (3) @(negedge clk);
    check("imm_busy", busy, 1);
    rst = 1'b1;
    #1 check("imm_rst_we", ram_we, 0);
    @(negedge clk);
    rst = 1'b0;
    check("imm_rst_busy", busy, 0);
    check("imm_rst_sp", dut.sp, 8'd255);
    check("imm_rst_tos_valid", tos_valid, 0);
    check("imm_rst_pc", pc, 0);
    repeat (10) @(negedge clk);
    check("imm_rst_ram", mem[254], 32'hDEADBEEF);

    // Reset landing on the WRITE cycle of a push0.
    ipc = 16'd0;
    run_vec(mk(0, 8'h10, 32'd10, 32'd10, 1, 8'd254, 16'd5, 0, 0, 8, 1, 1, 8'd255, 32'd10));
    mem[254] = 32'hDEADBEEF;
    rom[5] = 8'h11;
    step_only();
    repeat (2) @(negedge clk);
    check("wr_pre_we", ram_we, 1);
    rst = 1'b1;
    #1 check("wr_rst_we", ram_we, 0);
    @(negedge clk);
    rst = 1'b0;
    check("wr_rst_busy", busy, 0);
    check("wr_rst_sp", dut.sp, 8'd255);
    check("wr_rst_tos_valid", tos_valid, 0);
    repeat (3) @(negedge clk);
    check("wr_rst_ram", mem[254], 32'hDEADBEEF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
